// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit producing a 2*WIDTH result into Hi/Lo.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division, one bit per
// cycle over WIDTH cycles. A one-cycle sign fixup follows, then a Done pulse.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] prod_q, prod_d;     // {acc/remainder, multiplier/quotient}
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_dvd_q, neg_dvd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_trial;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   quo, rem;

  // Next-state, datapath iteration and result fixup
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_dvd_d = neg_dvd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;

    a_neg = Op[0] & A[WIDTH-1];
    b_neg = Op[0] & B[WIDTH-1];
    a_mag = a_neg ? -A : A;
    b_mag = b_neg ? -B : B;

    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    // Remainder lives in the upper half; shift in the next dividend bit.
    div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_q};

    prod_neg = -prod_q;
    quo      = prod_q[WIDTH-1:0];
    rem      = prod_q[2*WIDTH-1:WIDTH];

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          op_d      = Op;
          opnd_d    = Op[1] ? b_mag : a_mag;
          prod_d    = {{WIDTH{1'b0}}, (Op[1] ? a_mag : b_mag)};
          neg_res_d = a_neg ^ b_neg;
          neg_dvd_d = a_neg;
          cnt_d     = '0;
          if (Op[1] && (B == '0)) begin
            hi_d    = A;
            lo_d    = '1;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (op_q[1]) begin
          if (!div_trial[WIDTH])
            prod_d = {div_trial[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
          else
            prod_d = {div_shift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
        end else begin
          prod_d = {mul_sum, prod_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1))
          state_d = FIXUP;
      end
      FIXUP: begin
        if (op_q[1]) begin
          lo_d = (op_q[0] && neg_res_q) ? -quo : quo;
          hi_d = (op_q[0] && neg_dvd_q) ? -rem : rem;
        end else if (op_q[0] && neg_res_q) begin
          hi_d = prod_neg[2*WIDTH-1:WIDTH];
          lo_d = prod_neg[WIDTH-1:0];
        end else begin
          hi_d = prod_q[2*WIDTH-1:WIDTH];
          lo_d = prod_q[WIDTH-1:0];
        end
        dbz_d   = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      opnd_q    <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_dvd_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      prod_q    <= prod_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_dvd_q <= neg_dvd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
    end
  end

  assign Busy      = (state_q == CALC) || (state_q == FIXUP);
  assign Done      = (state_q == DONE);
  assign Hi        = hi_q;
  assign Lo        = lo_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit (WIDTH=32): directed vectors push
// expected Hi/Lo/DivByZero, completion cycle and busy-cycle count; a monitor
// pops and compares on every Done and checks that Hi/Lo hold in between.
module tb_hilo_muldiv_unit;
  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         Start = 1'b0;
  logic [1:0]   Op = 2'b00;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Busy, Done, DivByZero;
  logic [W-1:0] Hi, Lo;

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo), .DivByZero(DivByZero)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           done_cyc;
    int           busy;
  } exp_t;

  exp_t sb[$];
  int tests = 0, fails = 0;
  int done_cnt = 0, ops_issued = 0, busy_cnt = 0;
  logic [W-1:0] last_hi = '0, last_lo = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compare on each Done, otherwise require Hi/Lo to hold
  always @(negedge Clk) begin
    if (!Rst) begin
      busy_cnt = 0;
      last_hi  = '0;
      last_lo  = '0;
    end else begin
      if (Busy) busy_cnt++;
      if (Done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got Done=1 expected no pending op (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("hi", 64'(Hi), 64'(e.hi));
          chk("lo", 64'(Lo), 64'(e.lo));
          chk("div_by_zero", 64'(DivByZero), 64'(e.dbz));
          chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
          chk("busy_cycles", 64'(busy_cnt), 64'(e.busy));
        end
        busy_cnt = 0;
        last_hi  = Hi;
        last_lo  = Lo;
      end else begin
        chk("hilo_hold", {Hi, Lo}, {last_hi, last_lo});
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz,
                       output int start_cyc);
    exp_t e;
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    start_cyc  = cyc;
    e.hi       = ehi;
    e.lo       = elo;
    e.dbz      = edbz;
    e.done_cyc = cyc + (edbz ? 1 : W + 2);
    e.busy     = edbz ? 0 : W + 1;
    sb.push_back(e);
    ops_issued++;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 80 && done_cnt < ops_issued; i++) @(negedge Clk);
    if (done_cnt < ops_issued) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got %0d completions expected %0d", done_cnt, ops_issued);
      ops_issued = done_cnt;
      sb.delete();
    end
    @(negedge Clk);
  endtask

  task automatic run(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz);
    int s;
    issue(op, a, b, ehi, elo, edbz, s);
    wait_done();
  endtask

  task automatic chk_idle_zero(input string nm);
    chk({nm, "_busy"}, 64'(Busy), 64'd0);
    chk({nm, "_done"}, 64'(Done), 64'd0);
    chk({nm, "_hi"}, 64'(Hi), 64'd0);
    chk({nm, "_lo"}, 64'(Lo), 64'd0);
    chk({nm, "_dbz"}, 64'(DivByZero), 64'd0);
  endtask

  initial begin
    int s;
    repeat (2) @(negedge Clk);
    chk_idle_zero("reset");
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    chk("no_start_after_reset", 64'(Busy), 64'd0);

    // Op: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
    run(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run(2'b01, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    run(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0);
    run(2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run(2'b11, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    run(2'b11, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 1'b0);
    run(2'b10, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1);
    run(2'b10, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0);
    run(2'b10, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0);
    run(2'b11, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);
    run(2'b00, 32'h0000ABCD, 32'h00010000, 32'h00000000, 32'hABCD0000, 1'b0);

    // Reset in cycle 10 of a MULTU discards it and clears the outputs
    issue(2'b00, 32'd123, 32'd456, 32'd0, 32'd56088, 1'b0, s);
    for (int i = 0; i < 100 && cyc < s + 10; i++) @(negedge Clk);
    chk("busy_before_reset", 64'(Busy), 64'd1);
    Rst = 1'b0;
    #1;
    chk_idle_zero("mid_op_reset");
    sb.delete();
    ops_issued = done_cnt;
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    chk("no_start_after_release", 64'(Busy), 64'd0);
    run(2'b00, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0);

    // Start pulses while busy (cycle 5) and in DONE (cycle 34) are ignored
    issue(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, s);
    for (int i = 0; i < 100 && cyc < s + 5; i++) @(negedge Clk);
    Start = 1'b1; Op = 2'b11; A = 32'd99; B = 32'd3;
    @(negedge Clk);
    Start = 1'b0;
    for (int i = 0; i < 100 && cyc < s + W + 2; i++) @(negedge Clk);
    chk("done_at_34", 64'(Done), 64'd1);
    Start = 1'b1; Op = 2'b10; A = 32'd5; B = 32'd0;
    @(negedge Clk);
    Start = 1'b0;
    wait_done();
    repeat (6) @(negedge Clk);
    chk("single_done", 64'(done_cnt), 64'(ops_issued));
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
Parametrised iterative multiply/divide unit producing a 2*WIDTH result into Hi/Lo. It is the sequential successor to the single-cycle HiLo path: MULT/MULTU/DIV/DIVU execute over WIDTH+2 cycles behind a start/busy/done handshake. It sits beside the ALU32Bit, takes its operands from RF_RD1/RF_RD2, and the datapath controller stalls the PC while Busy is high.

Parameters:
WIDTH, 32, operand width in bits; Hi and Lo are each WIDTH bits; legal range 4 to 64.

Ports:
Clk  in  1  clock; all state changes on rising edge
Rst  in  1  reset; asynchronous, active-low
Start  in  1  request; sampled only in IDLE
Op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with Start
A  in  WIDTH  multiplicand or dividend; sampled with Start
B  in  WIDTH  multiplier or divisor; sampled with Start
Busy  out  1  high in CALC and FIXUP
Done  out  1  one-cycle pulse; Hi/Lo valid and updated
Hi  out  WIDTH  product high half, or remainder
Lo  out  WIDTH  product low half, or quotient
DivByZero  out  1  set when a divide completes with B==0; held until next Done

Behaviour:
- Reset (Rst=0, any time, including mid-operation): state=IDLE; Busy=0, Done=0, Hi=0, Lo=0, DivByZero=0; the in-flight operation is discarded. Deasserting Rst does not start an operation.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE: when Start=1, latch Op. Latch |A| and |B| for signed ops; latch raw A and B for unsigned ops. Latch a sign-of-result flag and a sign-of-dividend flag. Go to CALC, except divide with B==0, which goes to DONE.
- CALC: exactly WIDTH cycles, controlled by an iteration counter of width clog2(WIDTH)+1.
  - Multiply: shift-add; one multiplier bit per cycle.
  - Divide: restoring; one quotient bit per cycle.
  - After the last iteration, go to FIXUP.
- FIXUP: 1 cycle.
  - Signed multiply: two's-complement negate the 2*WIDTH product if the operand signs differ.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Unsigned ops: pass through.
  - Hi/Lo registers load at the end of FIXUP. Go to DONE.
- DONE: Done=1 for exactly one cycle. Return to IDLE. Start is ignored in DONE; back-to-back operations are spaced by one IDLE cycle minimum.
- Latency: Start high in cycle 0 gives Done in cycle WIDTH+2 (34 for WIDTH=32). Divide by zero gives Done in cycle 1.
- Divide by zero result: Hi=A (raw), Lo=all ones, DivByZero=1. For any non-zero-divisor completion, DivByZero=0.
- Overflow case, DIV of most-negative by -1: quotient=most-negative, remainder=0. This falls out of the magnitude arithmetic; no special case and no flag.
- Start while Busy or in DONE: ignored; inputs are not re-sampled.
- Hi/Lo change only at FIXUP→DONE or in the divide-by-zero IDLE→DONE transition. Otherwise they hold their last result.
- Outputs are registered; no combinational path from the inputs to any output.

Test Plan:
- Rst low mid-CALC (cycle 10 of a MULTU) → next edge: Busy=0, Hi=Lo=0. A new Start after release → correct result in 34 cycles.
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF → Done in cycle 34; Hi=0xFFFFFFFE, Lo=0x00000001; Busy high cycles 1–33.
- MULT A=0xFFFFFFFD (-3) B=5 → Hi=0xFFFFFFFF, Lo=0xFFFFFFF1.
- DIV A=0xFFFFFFF9 (-7) B=2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIV A=0x80000000 B=0xFFFFFFFF → Lo=0x80000000, Hi=0.
- DIVU A=0x1234 B=0 → Done in cycle 1; Hi=0x1234, Lo=0xFFFFFFFF, DivByZero=1. A following DIVU 100/7 → Lo=14, Hi=2, DivByZero=0.
- Start with different operands pulsed in cycles 5 and 34 of a running MULTU 6*7 → result still Hi=0, Lo=42; exactly one Done pulse.
